system_qsys_sysid_checker: RTL and testbench

Avalon-MM master that reads the system ID peripheral (ID word at address 0, timestamp word at address 1) after a start pulse and compares both words against build-time expected values. It sits next to the sysid slave in the Qsys system and lets hardware (boot sequencer, LED status, JTAG debug) confirm that the loaded FPGA image matches the software build without involving the Nios II core. Results are sticky until the next check.

---
 rtl/system_qsys_sysid_checker.sv | 144 ++++++++++++++
 tb/tb_system_qsys_sysid_checker.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_qsys_sysid_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words after a start pulse
// and compares them against build-time expected values; results stay sticky until the next check.
module system_qsys_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1539307324,
  parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_ID,
    S_RSP_ID,
    S_REQ_TS,
    S_RSP_TS,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic        r_pass;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic        w_exit;
  logic        w_expire;

  // Exit condition of the current transaction state; it beats the timeout on the same cycle.
  always_comb begin
    w_exit   = 1'b0;
    w_expire = 1'b0;
    case (r_state)
      S_REQ_ID, S_REQ_TS: w_exit = ~avm_waitrequest;
      S_RSP_ID, S_RSP_TS: w_exit = avm_readdatavalid;
      default:            w_exit = 1'b0;
    endcase
    if ((r_state == S_REQ_ID) || (r_state == S_RSP_ID) ||
        (r_state == S_REQ_TS) || (r_state == S_RSP_TS)) begin
      w_expire = ~w_exit && (r_cnt == (TIMEOUT_CYCLES - 16'd1));
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_REQ_ID;
      S_REQ_ID: if (w_exit) w_next = S_RSP_ID; else if (w_expire) w_next = S_DONE;
      S_RSP_ID: if (w_exit) w_next = S_REQ_TS; else if (w_expire) w_next = S_DONE;
      S_REQ_TS: if (w_exit) w_next = S_RSP_TS; else if (w_expire) w_next = S_DONE;
      S_RSP_TS: if (w_exit || w_expire) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_pass     <= 1'b0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt      <= '0;
            r_pass     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
          end
        end
        S_REQ_ID, S_REQ_TS: begin
          r_cnt <= r_cnt + 16'd1;
          if (w_expire) r_timeout <= 1'b1;
        end
        S_RSP_ID: begin
          if (avm_readdatavalid) begin
            r_id_value <= avm_readdata;
            r_id_ok    <= (avm_readdata == EXPECTED_ID);
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
            if (w_expire) r_timeout <= 1'b1;
          end
        end
        S_RSP_TS: begin
          // pass is formed on entry to DONE so it changes together with the done pulse.
          if (avm_readdatavalid) begin
            r_ts_value <= avm_readdata;
            r_ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
            r_pass     <= r_id_ok && (avm_readdata == EXPECTED_TIMESTAMP);
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
            if (w_expire) r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign avm_read    = (r_state == S_REQ_ID) || (r_state == S_REQ_TS);
  assign avm_address = (r_state == S_REQ_TS);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign pass        = r_pass;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign timeout     = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_system_qsys_sysid_checker.sv
// Bench for system_qsys_sysid_checker: reactive sysid slave model plus a done-pulse scoreboard.
module tb_system_qsys_sysid_checker;

  localparam logic [31:0] GOOD_ID = 32'd0;
  localparam logic [31:0] GOOD_TS = 32'd1539307324;
  localparam int          TO_CYC  = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  system_qsys_sysid_checker #(
    .EXPECTED_ID        (GOOD_ID),
    .EXPECTED_TIMESTAMP (GOOD_TS),
    .TIMEOUT_CYCLES     (16'(TO_CYC))
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .id_ok             (id_ok),
    .ts_ok             (ts_ok),
    .timeout           (timeout),
    .id_value          (id_value),
    .ts_value          (ts_value)
  );

  typedef struct {
    logic        p;
    logic        iok;
    logic        tok;
    logic        to;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          dcyc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;

  // slave model configuration
  int          ws = 0;
  int          lat = 1;
  bit          stuck = 1'b0;
  bit          inject = 1'b0;
  logic [31:0] id_word = GOOD_ID;
  logic [31:0] ts_word = GOOD_TS;
  int          rd_hi = 0;

  initial forever #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1, "watchdog");
  end

  // Avalon slave model: drives on the falling edge, DUT samples on the rising edge.
  initial begin
    int   pending;
    int   wcnt;
    bit   prev_stall;
    logic prev_addr;
    logic paddr;
    pending = 0; wcnt = 0; prev_stall = 1'b0; prev_addr = 1'b0; paddr = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
      if (!reset_n) begin
        pending = 0; wcnt = 0; prev_stall = 1'b0;
        avm_waitrequest = 1'b0;
        continue;
      end
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = paddr ? ts_word : id_word;
        end
      end
      if (inject) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'hDEADBEEF;
        inject = 1'b0;
      end
      if (prev_stall && !stuck) begin
        checks++;
        if (avm_read !== 1'b1 || avm_address !== prev_addr) begin
          failures++;
          $display("FAIL stall_hold: read=%b addr=%b, required read=1 addr=%b", avm_read, avm_address, prev_addr);
        end
      end
      if (avm_read === 1'b1) begin
        rd_hi++;
        if (stuck) begin
          avm_waitrequest = 1'b1;
          prev_stall = 1'b0;
        end else if (wcnt < ws) begin
          avm_waitrequest = 1'b1;
          wcnt++;
          prev_stall = 1'b1;
          prev_addr = avm_address;
        end else begin
          avm_waitrequest = 1'b0;
          wcnt = 0;
          prev_stall = 1'b0;
          pending = lat;
          paddr = avm_address;
        end
      end else begin
        avm_waitrequest = 1'b0;
        prev_stall = 1'b0;
      end
    end
  end

  // Scoreboard: every done pulse pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_done: got done at cycle %0d, required no done", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.dcyc) begin
            failures++;
            $display("FAIL sb_done_cycle: got %0d required %0d", cyc, e.dcyc);
          end
          checks++;
          if (pass !== e.p) begin failures++; $display("FAIL sb_pass: got %b required %b", pass, e.p); end
          checks++;
          if (id_ok !== e.iok) begin failures++; $display("FAIL sb_id_ok: got %b required %b", id_ok, e.iok); end
          checks++;
          if (ts_ok !== e.tok) begin failures++; $display("FAIL sb_ts_ok: got %b required %b", ts_ok, e.tok); end
          checks++;
          if (timeout !== e.to) begin failures++; $display("FAIL sb_timeout: got %b required %b", timeout, e.to); end
          checks++;
          if (id_value !== e.idv) begin failures++; $display("FAIL sb_id_value: got %0d required %0d", id_value, e.idv); end
          checks++;
          if (ts_value !== e.tsv) begin failures++; $display("FAIL sb_ts_value: got %0d required %0d", ts_value, e.tsv); end
        end
      end
    end
  end

  task automatic pulse_start(output int ns);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 ns = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic exp_t mk(logic p, logic iok, logic tok, logic to,
                              logic [31:0] idv, logic [31:0] tsv, int dcyc);
    exp_t e;
    e.p = p; e.iok = iok; e.tok = tok; e.to = to; e.idv = idv; e.tsv = tsv; e.dcyc = dcyc;
    return e;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, pass, id_ok, ts_ok, timeout, avm_read, avm_address} !== 8'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 00000000",
               {busy, done, pass, id_ok, ts_ok, timeout, avm_read, avm_address});
    end
    checks++;
    if (id_value !== 32'd0 || ts_value !== 32'd0) begin
      failures++;
      $display("FAIL reset_values: got id=%0d ts=%0d required 0/0", id_value, ts_value);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_pass();
    int ns;
    int base;
    bit ok;
    ws = 0; lat = 1; id_word = GOOD_ID; ts_word = GOOD_TS;
    base = done_cnt;
    pulse_start(ns);
    sb.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, GOOD_ID, GOOD_TS, ns + 4));
    wait_done(base, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL pass_wait: got no done, required done"); end
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL pass_busy_low: got %b required 0", busy); end
    checks++;
    if (pass !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL pass_sticky: got pass=%b done=%b required 1/0", pass, done);
    end
  endtask

  task automatic test_ts_mismatch();
    int ns;
    int base;
    bit ok;
    ws = 0; lat = 1; id_word = GOOD_ID; ts_word = GOOD_TS + 32'd1;
    base = done_cnt;
    pulse_start(ns);
    sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, GOOD_ID, GOOD_TS + 32'd1, ns + 4));
    wait_done(base, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL mismatch_wait: got no done, required done"); end
    ts_word = GOOD_TS;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_stall();
    int ns;
    int base;
    bit ok;
    ws = 3; lat = 2; id_word = GOOD_ID; ts_word = GOOD_TS;
    base = done_cnt;
    pulse_start(ns);
    sb.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, GOOD_ID, GOOD_TS, ns + 4 + 2 * 3 + 2 * 1));
    wait_done(base, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stall_wait: got no done, required done"); end
    ws = 0; lat = 1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_timeout();
    int ns;
    int base;
    bit ok;
    stuck = 1'b1;
    rd_hi = 0;
    base = done_cnt;
    pulse_start(ns);
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, ns + TO_CYC));
    wait_done(base, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL timeout_wait: got no done, required done"); end
    stuck = 1'b0;
    @(negedge clock);
    checks++;
    if (rd_hi !== TO_CYC) begin failures++; $display("FAIL timeout_read_cycles: got %0d required %0d", rd_hi, TO_CYC); end
    id_word = 32'h1234_5678;
    inject = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (id_value !== 32'd0 || ts_value !== 32'd0 || timeout !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_late_rdv: got id=%h ts=%h to=%b busy=%b required 0/0/1/0",
               id_value, ts_value, timeout, busy);
    end
    id_word = GOOD_ID;
  endtask

  task automatic test_start_ignored();
    int ns;
    int base;
    bit ok;
    ws = 0; lat = 1; ts_word = GOOD_TS;
    base = done_cnt;
    pulse_start(ns);
    sb.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, GOOD_ID, GOOD_TS, ns + 4));
    @(negedge clock); start = 1'b1;   // sampled while in RSP_ID
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock); start = 1'b1;   // sampled while in DONE
    @(negedge clock); start = 1'b0;
    repeat (10) @(negedge clock);
    checks++;
    if (done_cnt !== base + 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_done_count: got %0d busy=%b required %0d busy=0", done_cnt - base, busy, 1);
    end
    ts_word = GOOD_TS + 32'd7;
    base = done_cnt;
    pulse_start(ns);
    checks++;
    if (pass !== 1'b0 || id_ok !== 1'b0 || ts_ok !== 1'b0 || ts_value !== 32'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_clear: got pass=%b id_ok=%b ts_ok=%b ts=%0d busy=%b required 0/0/0/0/1",
               pass, id_ok, ts_ok, ts_value, busy);
    end
    sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, GOOD_ID, GOOD_TS + 32'd7, ns + 4));
    wait_done(base, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL restart_wait: got no done, required done"); end
    ts_word = GOOD_TS;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int ns;
    int base;
    bit ok;
    ws = 0; lat = 1; id_word = GOOD_ID; ts_word = GOOD_TS;
    base = done_cnt;
    pulse_start(ns);
    repeat (3) @(negedge clock);
    checks++;
    if (id_ok !== 1'b1 || avm_read !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre: got id_ok=%b read=%b busy=%b required 1/0/1", id_ok, avm_read, busy);
    end
    reset_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({busy, done, pass, id_ok, ts_ok, timeout, avm_read} !== 7'b0 || id_value !== 32'd0 || ts_value !== 32'd0) begin
      failures++;
      $display("FAIL midreset_async: got flags=%b id=%0d ts=%0d required 0",
               {busy, done, pass, id_ok, ts_ok, timeout, avm_read}, id_value, ts_value);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (done_cnt !== base) begin failures++; $display("FAIL midreset_no_done: got %0d required %0d", done_cnt, base); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    base = done_cnt;
    pulse_start(ns);
    sb.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, GOOD_ID, GOOD_TS, ns + 4));
    wait_done(base, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midreset_rerun_wait: got no done, required done"); end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_ts_mismatch();
    test_stall();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending entries required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
